// File: rtl/regional_max_ctrl.sv
// regional_max_ctrl
// -----------------
// Sequencer for the iterative regional-maximum engine.
// After a start command it fills the M x N output mask with ones. It then
// issues raster-scan passes of pixel coordinates, with border flags, to the
// 3x3 window PE. Passes repeat until one pass produces no mask change or the
// pass limit is reached.
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   start                begin operation (sampled only in IDLE)
//   busy / done          activity flag / one-cycle completion pulse
//   converged, pass_cnt  result status, held until the next start
//   mask_we/addr/wdata   mask initialisation write port
//   pix_valid/ready      request handshake to the PE
//   pix_i/j/addr/border  request coordinates, linear address, {top,bottom,left,right}
//   upd_valid/changed    in-order PE result; changed = mask bit cleared
module regional_max_ctrl #(
    parameter int M          = 8,
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int I_WIDTH    = 3,
    parameter int J_WIDTH    = 3,
    parameter int MAX_PASS   = 64,
    parameter int PASS_WIDTH = 7,
    parameter int MAX_OUT    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [PASS_WIDTH-1:0] pass_cnt,
    output logic                  mask_we,
    output logic [ADDR_WIDTH-1:0] mask_addr,
    output logic                  mask_wdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [I_WIDTH-1:0]    pix_i,
    output logic [J_WIDTH-1:0]    pix_j,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    output logic [3:0]            pix_border,
    input  logic                  upd_valid,
    input  logic                  upd_changed
);

    localparam int OUT_WIDTH = $clog2(MAX_OUT + 1);
    localparam int CELLS     = M * N;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SCAN,
        S_DRAIN,
        S_EVAL,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_init_addr;
    logic [I_WIDTH-1:0]    r_i;
    logic [J_WIDTH-1:0]    r_j;
    logic [OUT_WIDTH-1:0]  r_out;
    logic [OUT_WIDTH-1:0]  w_out_next;
    logic [PASS_WIDTH-1:0] r_pass;
    logic                  r_changed;
    logic                  r_converged;

    logic w_can_issue;
    logic w_accept;
    logic w_upd;
    logic w_row_end;
    logic w_last_pix;
    logic w_init_last;

    always_comb begin
        w_can_issue = (r_out < OUT_WIDTH'(MAX_OUT));
        w_accept    = (r_state == S_SCAN) && w_can_issue && pix_ready;
        // Updates only count while a pass is active and something is in
        // flight; stray results elsewhere must not underflow the counter.
        w_upd       = upd_valid && ((r_state == S_SCAN) || (r_state == S_DRAIN))
                      && (r_out != '0);
        w_row_end   = (r_j == J_WIDTH'(N - 1));
        w_last_pix  = w_row_end && (r_i == I_WIDTH'(M - 1));
        w_init_last = (r_init_addr == ADDR_WIDTH'(CELLS - 1));

        w_out_next = r_out;
        if (w_accept && !w_upd) begin
            w_out_next = r_out + OUT_WIDTH'(1);
        end else if (!w_accept && w_upd) begin
            w_out_next = r_out - OUT_WIDTH'(1);
        end
    end

    // Next-state and outputs
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        mask_we      = (r_state == S_INIT);
        mask_addr    = r_init_addr;
        mask_wdata   = 1'b1;
        pix_valid    = (r_state == S_SCAN) && w_can_issue;
        pix_i        = r_i;
        pix_j        = r_j;
        pix_addr     = ADDR_WIDTH'(r_i) * ADDR_WIDTH'(N) + ADDR_WIDTH'(r_j);
        // Border flags are only meaningful alongside a request; keep them
        // quiet otherwise so idle/reset shows all zeros.
        pix_border   = 4'b0000;
        if (pix_valid) begin
            pix_border = {r_i == '0, r_i == I_WIDTH'(M - 1),
                          r_j == '0, r_j == J_WIDTH'(N - 1)};
        end
        converged    = r_converged;
        pass_cnt     = r_pass;

        case (r_state)
            S_IDLE:  if (start) w_state_next = S_INIT;
            S_INIT:  if (w_init_last) w_state_next = S_SCAN;
            S_SCAN:  if (w_accept && w_last_pix) w_state_next = S_DRAIN;
            // Includes an update landing this very cycle.
            S_DRAIN: if (w_out_next == '0) w_state_next = S_EVAL;
            S_EVAL: begin
                if (r_changed && (r_pass < PASS_WIDTH'(MAX_PASS))) begin
                    w_state_next = S_SCAN;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_init_addr <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_out       <= '0;
            r_pass      <= '0;
            r_changed   <= 1'b0;
            r_converged <= 1'b0;
        end else begin
            r_out <= w_out_next;
            if (w_upd && upd_changed) begin
                r_changed <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pass      <= '0;
                        r_converged <= 1'b0;
                        r_init_addr <= '0;
                    end
                end
                S_INIT: begin
                    if (w_init_last) begin
                        r_init_addr <= '0;
                        r_pass      <= PASS_WIDTH'(1);
                        r_changed   <= 1'b0;
                        r_i         <= '0;
                        r_j         <= '0;
                    end else begin
                        r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
                    end
                end
                S_SCAN: begin
                    if (w_accept) begin
                        if (w_row_end) begin
                            r_j <= '0;
                            r_i <= (r_i == I_WIDTH'(M - 1)) ? '0 : r_i + I_WIDTH'(1);
                        end else begin
                            r_j <= r_j + J_WIDTH'(1);
                        end
                    end
                end
                S_EVAL: begin
                    if (w_state_next == S_SCAN) begin
                        r_pass    <= r_pass + PASS_WIDTH'(1);
                        r_changed <= 1'b0;
                        r_i       <= '0;
                        r_j       <= '0;
                    end else begin
                        r_converged <= ~r_changed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regional_max_ctrl.sv
module tb_regional_max_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       busy, done, converged;
    logic [6:0] pass_cnt;
    logic       mask_we;
    logic [5:0] mask_addr;
    logic       mask_wdata;
    logic       pix_valid;
    logic       pix_ready;
    logic [2:0] pix_i, pix_j;
    logic [5:0] pix_addr;
    logic [3:0] pix_border;
    logic       upd_valid, upd_changed;

    regional_max_ctrl #(
        .M(8), .N(8), .ADDR_WIDTH(6), .I_WIDTH(3), .J_WIDTH(3),
        .MAX_PASS(3), .PASS_WIDTH(7), .MAX_OUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .converged(converged), .pass_cnt(pass_cnt),
        .mask_we(mask_we), .mask_addr(mask_addr), .mask_wdata(mask_wdata),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_i(pix_i), .pix_j(pix_j), .pix_addr(pix_addr), .pix_border(pix_border),
        .upd_valid(upd_valid), .upd_changed(upd_changed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int j;
        int addr;
        int border;
    } pix_t;

    typedef struct {
        int   due;
        logic chg;
    } pend_t;

    typedef struct {
        int i;
        int j;
        int border;
        int addr;
    } bvec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    int    exp_mask[$];
    pix_t  exp_pix[$];
    pend_t pend[$];

    logic  ready_mode = 1'b0;
    logic  chg_all    = 1'b0;
    logic  withhold   = 1'b0;
    logic  inj_upd    = 1'b0;

    int    tb_out      = 0;
    int    run_acc     = 0;
    logic  ovf         = 1'b0;
    logic  stable_bad  = 1'b0;
    int    first_valid = -1;
    int    start_cyc   = -1;
    logic  done_seen   = 1'b0;
    int    done_pass   = 0;
    logic  done_conv   = 1'b0;
    int    obs_border[64];
    int    obs_addr[64];

    logic       m_acc;
    logic       hold_v = 1'b0;
    logic [2:0] hold_i, hold_j;
    logic [5:0] hold_addr;
    logic [3:0] hold_border;

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // PE model and output monitor: drives inputs on the falling edge and
    // samples DUT outputs 1 time unit later.
    initial begin
        pix_ready   = 1'b1;
        upd_valid   = 1'b0;
        upd_changed = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            pix_ready   = ready_mode ? ~pix_ready : 1'b1;
            upd_valid   = 1'b0;
            upd_changed = 1'b0;
            if (inj_upd) begin
                upd_valid   = 1'b1;
                upd_changed = 1'b1;
            end else if (!withhold && pend.size() > 0 && pend[0].due <= cyc) begin
                upd_valid   = 1'b1;
                upd_changed = pend[0].chg;
                void'(pend.pop_front());
            end
            #1;
            if (!reset_n) begin
                pend.delete();
                tb_out = 0;
                hold_v = 1'b0;
            end else begin
                m_acc = pix_valid && pix_ready;
                if (start && !busy) start_cyc = cyc;
                if (pix_valid && first_valid < 0) first_valid = cyc;
                if (mask_we) begin
                    if (exp_mask.size() == 0) begin
                        chk("mask_extra_write", int'(mask_addr), -1);
                    end else begin
                        chk("mask_addr", int'(mask_addr), exp_mask.pop_front());
                        chk("mask_wdata", int'(mask_wdata), 1);
                    end
                end
                if (m_acc) begin
                    if (tb_out >= 4) ovf = 1'b1;
                    if (exp_pix.size() == 0) begin
                        chk("pix_extra_accept", int'(pix_addr), -1);
                    end else begin
                        pix_t p;
                        p = exp_pix.pop_front();
                        chk("pix_i", int'(pix_i), p.i);
                        chk("pix_j", int'(pix_j), p.j);
                        chk("pix_addr", int'(pix_addr), p.addr);
                        chk("pix_border", int'(pix_border), p.border);
                    end
                    obs_border[{pix_i, pix_j}] = int'(pix_border);
                    obs_addr[{pix_i, pix_j}]   = int'(pix_addr);
                    pend.push_back('{due: cyc + LAT, chg: chg_all || (run_acc < 64)});
                    run_acc++;
                    tb_out++;
                end
                if (upd_valid && !inj_upd) tb_out--;
                if (hold_v && pix_valid &&
                    (pix_i != hold_i || pix_j != hold_j ||
                     pix_addr != hold_addr || pix_border != hold_border))
                    stable_bad = 1'b1;
                hold_v      = pix_valid && !pix_ready;
                hold_i      = pix_i;
                hold_j      = pix_j;
                hold_addr   = pix_addr;
                hold_border = pix_border;
                if (done) begin
                    done_seen = 1'b1;
                    done_pass = int'(pass_cnt);
                    done_conv = converged;
                end
            end
        end
    end

    task automatic prep(input logic chg, input logic rmode, input int npass);
        ready_mode = rmode;
        chg_all    = chg;
        exp_mask.delete();
        exp_pix.delete();
        for (int a = 0; a < 64; a++) exp_mask.push_back(a);
        for (int p = 0; p < npass; p++)
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    exp_pix.push_back('{i: i, j: j, addr: i * 8 + j,
                        border: {28'd0, i == 0, i == 7, j == 0, j == 7}});
        run_acc     = 0;
        ovf         = 1'b0;
        stable_bad  = 1'b0;
        first_valid = -1;
        start_cyc   = -1;
        done_seen   = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic finish_run(input string nm, input int npass, input logic conv);
        for (int k = 0; k < 3000 && !done_seen; k++) begin
            @(negedge clk);
            #2;
        end
        chk({nm, "_done_seen"}, int'(done_seen), 1);
        chk({nm, "_pass_cnt"}, done_pass, npass);
        chk({nm, "_converged"}, int'(done_conv), int'(conv));
        chk({nm, "_first_valid_latency"}, first_valid - start_cyc, 65);
        chk({nm, "_mask_writes_left"}, exp_mask.size(), 0);
        chk({nm, "_requests_left"}, exp_pix.size(), 0);
        chk({nm, "_accept_over_limit"}, int'(ovf), 0);
        chk({nm, "_held_fields_moved"}, int'(stable_bad), 0);
        @(negedge clk);
        #2;
        chk({nm, "_done_one_cycle"}, int'(done), 0);
        chk({nm, "_busy_after_done"}, int'(busy), 0);
        chk({nm, "_pass_cnt_held"}, int'(pass_cnt), npass);
        chk({nm, "_converged_held"}, int'(converged), int'(conv));
    endtask

    initial begin
        bvec_t tbl[5];
        tbl[0] = '{i: 0, j: 7, border: 4'b1001, addr: 7};
        tbl[1] = '{i: 7, j: 0, border: 4'b0110, addr: 56};
        tbl[2] = '{i: 3, j: 4, border: 4'b0000, addr: 28};
        tbl[3] = '{i: 7, j: 7, border: 4'b0101, addr: 63};
        tbl[4] = '{i: 0, j: 0, border: 4'b1010, addr: 0};

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_converged", int'(converged), 0);
        chk("rst_pass_cnt", int'(pass_cnt), 0);
        chk("rst_mask_we", int'(mask_we), 0);
        chk("rst_mask_addr", int'(mask_addr), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_pix_addr", int'(pix_addr), 0);
        chk("rst_pix_border", int'(pix_border), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Converges on pass 2, PE always ready
        prep(1'b0, 1'b0, 2);
        kick();
        finish_run("conv", 2, 1'b1);
        foreach (tbl[k]) begin
            chk($sformatf("border_%0d_%0d", tbl[k].i, tbl[k].j),
                obs_border[tbl[k].i * 8 + tbl[k].j], tbl[k].border);
            chk($sformatf("addr_%0d_%0d", tbl[k].i, tbl[k].j),
                obs_addr[tbl[k].i * 8 + tbl[k].j], tbl[k].addr);
        end

        // Backpressure: ready toggles every cycle
        prep(1'b0, 1'b1, 2);
        kick();
        finish_run("toggle", 2, 1'b1);
        ready_mode = 1'b0;

        // Pass limit: every pass reports a change
        prep(1'b1, 1'b0, 3);
        kick();
        finish_run("limit", 3, 1'b0);

        // PE withholds results: issue must stall at four in flight
        prep(1'b0, 1'b0, 2);
        withhold = 1'b1;
        kick();
        for (int k = 0; k < 200 && tb_out < 4; k++) begin
            @(negedge clk);
            #2;
        end
        repeat (10) @(negedge clk);
        #2;
        chk("stall_accepts", run_acc, 4);
        chk("stall_valid_low", int'(pix_valid), 0);
        withhold = 1'b0;
        @(negedge clk);
        #2;
        chk("stall_valid_at_release", int'(pix_valid), 0);
        @(negedge clk);
        #2;
        chk("stall_issue_resumed", int'(pix_valid), 1);
        @(negedge clk);
        #2;
        chk("stall_accept_with_update", int'(pix_valid), 1);
        finish_run("stall", 2, 1'b1);

        // Stray results while idle must be ignored; start during a pass too
        @(negedge clk);
        inj_upd = 1'b1;
        repeat (2) @(negedge clk);
        inj_upd = 1'b0;
        prep(1'b0, 1'b0, 2);
        kick();
        for (int k = 0; k < 200 && run_acc < 10; k++) begin
            @(negedge clk);
            #2;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run("stray", 2, 1'b1);

        // Reset in the middle of a scan, presenting pixel (2,5)
        prep(1'b0, 1'b0, 2);
        kick();
        for (int k = 0; k < 300 && run_acc < 21; k++) begin
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        chk("midrst_target_i", int'(pix_i), 2);
        chk("midrst_target_j", int'(pix_j), 5);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #2;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pix_valid", int'(pix_valid), 0);
        chk("midrst_pass_cnt", int'(pass_cnt), 0);
        repeat (5) @(negedge clk);
        #2;
        chk("midrst_no_requests", int'(pix_valid), 0);
        prep(1'b0, 1'b0, 2);
        kick();
        finish_run("restart", 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
